// File: rtl/dmem_block_mover.sv
// Block copy / block fill engine that owns the data memory port while busy.
// Copy walks the range high-to-low when the destination lies above the source, so overlapping moves are safe.
module dmem_block_mover #(
  parameter int DEPTH = 200,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [LEN_W-1:0] length,
  input  logic [31:0]      fill_value,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             mem_write,
  output logic             mem_read,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_mode;
  logic             r_desc;
  logic             r_err;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_fill;
  logic [31:0]      r_buf;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_rem;

  logic [32:0]      w_dst_end;
  logic [32:0]      w_src_end;
  logic             w_range_err;
  logic             w_zero_len;
  logic             w_desc;
  logic             w_last;
  logic [31:0]      w_idx_ext;

  // 33-bit end addresses so a base near 2^32 cannot wrap into a valid range.
  assign w_dst_end   = {1'b0, dst_base} + {{(33-LEN_W){1'b0}}, length};
  assign w_src_end   = {1'b0, src_base} + {{(33-LEN_W){1'b0}}, length};
  assign w_range_err = (w_dst_end > 33'(DEPTH)) || (!mode && (w_src_end > 33'(DEPTH)));
  assign w_zero_len  = (length == '0);
  assign w_desc      = !mode && (dst_base > src_base);
  assign w_last      = (r_rem == {{(LEN_W-1){1'b0}}, 1'b1});
  assign w_idx_ext   = {{(32-LEN_W){1'b0}}, r_idx};

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_zero_len || w_range_err) w_next = S_DONE;
          else if (mode)                 w_next = S_WRITE;
          else                           w_next = S_READ;
        end
      end
      S_READ: begin
        mem_read = 1'b1;
        mem_addr = r_src + w_idx_ext;
        w_next   = S_WRITE;
      end
      S_WRITE: begin
        mem_write = 1'b1;
        mem_addr  = r_dst + w_idx_ext;
        mem_wdata = r_mode ? r_fill : r_buf;
        if (w_last)      w_next = S_DONE;
        else if (r_mode) w_next = S_WRITE;
        else             w_next = S_READ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_desc <= 1'b0;
      r_err  <= 1'b0;
      r_src  <= 32'h0;
      r_dst  <= 32'h0;
      r_fill <= 32'h0;
      r_buf  <= 32'h0;
      r_idx  <= '0;
      r_rem  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_desc <= w_desc;
            r_err  <= !w_zero_len && w_range_err;
            r_src  <= src_base;
            r_dst  <= dst_base;
            r_fill <= fill_value;
            r_rem  <= length;
            r_idx  <= w_desc ? (length - 1'b1) : '0;
          end
        end
        S_READ: r_buf <= mem_rdata;
        S_WRITE: begin
          if (!w_last) begin
            r_rem <= r_rem - 1'b1;
            r_idx <= r_desc ? (r_idx - 1'b1) : (r_idx + 1'b1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Scoreboard bench for dmem_block_mover: a word-array memory model, a memmove/fill reference
// and a negedge monitor that checks every memory access, done pulse, busy and err cycle by cycle.
module tb_dmem_block_mover;
  localparam int DEPTH = 200;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mode;
  logic [31:0]      src_base;
  logic [31:0]      dst_base;
  logic [LEN_W-1:0] length;
  logic [31:0]      fill_value;
  logic             busy, done, err, mem_write, mem_read;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_block_mover #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .length(length), .fill_value(fill_value),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    if (mem_write && (mem_addr < 32'(DEPTH))) mem[mem_addr[7:0]] <= mem_wdata;
    else if (pl_en)                           mem[pl_addr] <= pl_data;
  end
  assign mem_rdata = (mem_addr < 32'(DEPTH)) ? mem[mem_addr[7:0]] : 32'h0;

  typedef struct {
    int          kind;   // 0 read, 1 write, 2 done
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];
  exp_t e_mon;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   b_lo = 1000000;
  int   b_hi = -1;
  logic err_old = 1'b0;
  logic err_new = 1'b0;
  int   err_sw = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'((cyc >= b_lo) && (cyc <= b_hi)));
      chk("err", 32'(err), 32'((cyc >= err_sw) ? err_new : err_old));
      chk("rd_wr_exclusive", 32'(mem_read & mem_write), 32'h0);
      if (mem_read || mem_write || done) begin
        if (q.size() == 0) begin
          chk("unexpected_activity", {29'h0, done, mem_write, mem_read}, 32'h0);
        end else begin
          e_mon = q.pop_front();
          chk("kind", done ? 32'd2 : (mem_write ? 32'd1 : 32'd0), 32'(e_mon.kind));
          chk("cycle", 32'(cyc), 32'(e_mon.cyc));
          chk("addr", mem_addr, e_mon.addr);
          if (e_mon.kind == 1) chk("wdata", mem_wdata, e_mon.data);
          if (e_mon.kind == 2) chk("done_err", 32'(err), e_mon.data);
        end
      end else begin
        chk("idle_addr", mem_addr, 32'h0);
        chk("idle_wdata", mem_wdata, 32'h0);
      end
    end
  end

  task automatic push(input int k, input int c, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    x.kind = k; x.cyc = c; x.addr = a; x.data = d;
    q.push_back(x);
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    pl_en = 1'b1; pl_addr = 8'(a); pl_data = v;
    ref_mem[8'(a)] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'h0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that starts the first IDLE cycle.
  task automatic do_cmd(input bit m, input logic [31:0] s, input logic [31:0] d, input int n,
                        input logic [31:0] f, input int inj, input int rst_at);
    int          c0, endc, j, i;
    bit          e, desc;
    longint      sl, dl;
    logic [31:0] tmp [$];
    int          order [$];
    c0 = cyc;
    mode = m; src_base = s; dst_base = d; length = LEN_W'(n); fill_value = f; start = 1'b1;
    sl = s; dl = d;
    e = (n != 0) && ((dl + n > DEPTH) || (!m && (sl + n > DEPTH)));
    if (n == 0 || e) endc = 1;
    else if (m)      endc = n + 1;
    else             endc = 2 * n + 1;
    if (!(n == 0 || e)) begin
      desc = !m && (d > s);
      for (int k = 0; k < n; k++) order.push_back(desc ? (n - 1 - k) : k);
      if (!m) for (int k = 0; k < n; k++) tmp.push_back(ref_mem[8'(s + k)]);
      for (j = 0; j < n; j++) begin
        i = order[j];
        if (m) begin
          if (rst_at == 0 || (j + 1) < rst_at) begin
            push(1, c0 + j + 1, d + i, f);
            ref_mem[8'(d + i)] = f;
          end
        end else begin
          if (rst_at == 0 || (2 * j + 1) < rst_at) push(0, c0 + 2 * j + 1, s + i, 32'h0);
          if (rst_at == 0 || (2 * j + 2) < rst_at) begin
            push(1, c0 + 2 * j + 2, d + i, tmp[i]);
            ref_mem[8'(d + i)] = tmp[i];
          end
        end
      end
    end
    if (rst_at == 0) push(2, c0 + endc, 32'h0, {31'h0, e});
    err_old = (cyc >= err_sw) ? err_new : err_old;
    err_new = e;
    err_sw  = c0 + 1;
    b_lo    = c0 + 1;
    b_hi    = (rst_at != 0) ? (c0 + rst_at - 1) : (c0 + endc);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < c0 + endc + 1) begin
      if (rst_at != 0 && cyc == c0 + rst_at) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs("midop_reset");
        err_old = 1'b0; err_new = 1'b0; err_sw = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
      start = (inj != 0 && cyc == c0 + inj);
      if (start) begin
        mode = 1'b1; dst_base = 32'h0; length = LEN_W'(1); fill_value = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("queue_drained", 32'(q.size()), 32'h0);
    q.delete();
  endtask

  task automatic compare_mem(input string tag);
    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("%s_mem[%0d]", tag, k), mem[8'(k)], ref_mem[8'(k)]);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int          r, n, s, d;
    bit          m;
    logic [31:0] sa, da;
    rst = 1'b1; start = 1'b0; mode = 1'b0; src_base = 32'h0; dst_base = 32'h0;
    length = '0; fill_value = 32'h0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) preload(k, $urandom);

    do_cmd(1'b1, 32'd0, 32'd10, 4, 32'hA5A5_0001, 0, 0);
    preload(0, 32'd5); preload(1, 32'd6); preload(2, 32'd7);
    do_cmd(1'b0, 32'd0, 32'd50, 3, 32'h0, 0, 0);
    preload(20, 32'd1); preload(21, 32'd2); preload(22, 32'd3); preload(23, 32'd4);
    do_cmd(1'b0, 32'd20, 32'd22, 4, 32'h0, 0, 0);
    chk("overlap_mem22", mem[22], 32'd1);
    chk("overlap_mem25", mem[25], 32'd4);
    chk("overlap_mem21", mem[21], 32'd2);
    do_cmd(1'b1, 32'd0, 32'd5, 0, 32'h1234_5678, 0, 0);
    do_cmd(1'b1, 32'd0, 32'd198, 3, 32'h1111_2222, 0, 0);
    do_cmd(1'b0, 32'd199, 32'd0, 2, 32'h0, 0, 0);
    do_cmd(1'b1, 32'd0, 32'hFFFF_FFF0, 32, 32'h3333_4444, 0, 0);
    do_cmd(1'b0, 32'd30, 32'd28, 5, 32'h0, 0, 0);
    do_cmd(1'b1, 32'd0, 32'd100, 8, 32'h5555_0008, 3, 0);
    do_cmd(1'b1, 32'd0, 32'd100, 8, 32'h6666_0006, 0, 5);
    compare_mem("after_reset");
    do_cmd(1'b0, 32'd100, 32'd150, 4, 32'h0, 0, 0);
    do_cmd(1'b1, 32'd0, 32'd199, 1, 32'h7777_7777, 0, 0);

    for (int t = 0; t < 40; t++) begin
      m = 1'(($urandom & 1));
      r = int'($urandom_range(0, 9));
      if (r == 0)      n = 0;
      else if (r == 1) n = int'($urandom_range(150, 400));
      else             n = int'($urandom_range(1, 12));
      s = int'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) d = s + int'($urandom_range(0, 6)) - 3;
      else                           d = int'($urandom_range(0, DEPTH - 1));
      if (d < 0) d = 0;
      sa = 32'(s); da = 32'(d);
      if ($urandom_range(0, 15) == 0) da = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      do_cmd(m, sa, da, n, $urandom, 0, 0);
    end

    compare_mem("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
